// File: rtl/clock_pkg.sv
// Shared mode encodings, field limits and a BCD helper for the time-set controller.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10,
    ILLEGAL = 2'b11
  } mode_e;

  localparam int HR_MAX  = 23;
  localparam int MIN_MAX = 59;
  localparam int SEC_MAX = 59;

  function automatic logic [7:0] to_bcd(input int v);
    to_bcd = {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps MAX -> 00; carry flags the wrapping increment.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] value,
  output logic       carry
);

  localparam logic [7:0] MAX_BCD = to_bcd(MAX);

  assign carry = inc && !clr && (value == MAX_BCD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value <= 8'h00;
    end else if (clr) begin
      value <= 8'h00;
    end else if (inc) begin
      if (value == MAX_BCD)
        value <= 8'h00;
      else if (value[3:0] == 4'd9)
        value <= {value[7:4] + 4'd1, 4'd0};
      else
        value <= {value[7:4], value[3:0] + 4'd1};
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Clock time-keeping with button-driven hour/minute setting.
// Optional digit blinking while setting is built only when SET_BLINK_EN is defined.
//
// state   | meaning
// RUN     | time advances once per second, inc_tick ignored
// SET_HR  | prescaler held, inc_tick steps hours mod 24
// SET_MIN | prescaler held, inc_tick steps minutes mod 60; leaving clears seconds
// ILLEGAL | unreachable, returns to RUN
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 50000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       mode_tick,
  input  logic       inc_tick,
  output logic [7:0] hr_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [1:0] mode,
  output logic       blank_hr,
  output logic       blank_min
);

  localparam int              PW     = $clog2(CLK_HZ);
  localparam logic [PW-1:0]   PRE_TC = PW'(CLK_HZ - 1);

  mode_e          state_q, state_d;
  logic [PW-1:0]  pre_q;
  logic           sec_tick, sec_clr, inc_ok;
  logic           sec_carry, min_carry, hr_carry;
  logic           sec_inc, min_inc, hr_inc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= RUN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    sec_clr = 1'b0;
    inc_ok  = 1'b0;
    case (state_q)
      RUN:     if (mode_tick) state_d = SET_HR;
      SET_HR: begin
        if (mode_tick) state_d = SET_MIN;
        inc_ok = inc_tick && !mode_tick;
      end
      SET_MIN: begin
        if (mode_tick) state_d = RUN;
        sec_clr = mode_tick;
        inc_ok  = inc_tick && !mode_tick;
      end
      default: state_d = RUN;
    endcase
  end

  assign sec_tick = (state_q == RUN) && (pre_q == PRE_TC);

  // Outside RUN the prescaler sits at 0, so re-entering RUN starts a full second.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      pre_q <= '0;
    else if (state_q == RUN)
      pre_q <= sec_tick ? '0 : pre_q + 1'b1;
    else
      pre_q <= '0;
  end

  assign sec_inc = sec_tick;
  assign min_inc = sec_carry || (inc_ok && state_q == SET_MIN);
  // Only a seconds-driven minute wrap may ripple into hours.
  assign hr_inc  = (sec_carry && min_carry) || (inc_ok && state_q == SET_HR);

  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk(clk), .reset_n(reset_n), .inc(sec_inc), .clr(sec_clr),
    .value(sec_bcd), .carry(sec_carry)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk(clk), .reset_n(reset_n), .inc(min_inc), .clr(1'b0),
    .value(min_bcd), .carry(min_carry)
  );

  bcd_mod_counter #(.MAX(HR_MAX)) u_hr (
    .clk(clk), .reset_n(reset_n), .inc(hr_inc), .clr(1'b0),
    .value(hr_bcd), .carry(hr_carry)
  );

  assign mode = state_q;

`ifdef SET_BLINK_EN
  localparam int            BW       = $clog2(CLK_HZ / 4 + 1);
  localparam logic [BW-1:0] BLINK_TC = BW'(CLK_HZ / 4 - 1);

  logic [BW-1:0] blink_cnt_q;
  logic          blink_q;
  logic          blink_restart;

  assign blink_restart = (state_d != state_q) || inc_ok ||
                         !(state_q == SET_HR || state_q == SET_MIN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (blink_restart) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (blink_cnt_q == BLINK_TC) begin
      blink_cnt_q <= '0;
      blink_q     <= ~blink_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  assign blank_hr  = blink_q && (state_q == SET_HR);
  assign blank_min = blink_q && (state_q == SET_MIN);
`else
  assign blank_hr  = 1'b0;
  assign blank_min = 1'b0;
`endif

  logic unused_hr_carry;
  assign unused_hr_carry = hr_carry;

endmodule
